csr_trap_ctrl: RTL

Parametrised machine-mode CSR file and trap controller for the RV32IMA+Zicsr core. It generalises the CSR/exception unit with interrupt support (fixed M-mode sources plus `NUM_PLAT_IRQ` platform lines), `mret`, correct vectored dispatch, illegal-CSR detection, 64-bit counters and a registered trap request/acknowledge handshake toward the pipeline. It sits beside execute/writeback and owns every redirect caused by traps.

---
 rtl/csr_trap_ctrl_if.sv | 48 ++++
 rtl/csr_trap_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: pipeline-facing bundle of the CSR file / trap controller.
//   master : pipeline side (drives CSR access, exception, mret, interrupt, retire, trap_ack)
//   slave  : csr_trap_ctrl side (drives csr_rdata, csr_illegal, trap_req, trap_target)
// NUM_PLAT_IRQ must match the csr_trap_ctrl instance; a zero count still keeps one
// (unused) irq_plat bit so the vector is never zero-width.
interface csr_trap_ctrl_if #(
  parameter int unsigned NUM_PLAT_IRQ = 4
);
  localparam int unsigned PlatW = (NUM_PLAT_IRQ == 0) ? 1 : NUM_PLAT_IRQ;

  logic             csr_valid;
  logic [2:0]       csr_op;
  logic [11:0]      csr_addr;
  logic [31:0]      csr_wdata;
  logic [4:0]       csr_uimm;
  logic             csr_src_zero;
  logic [31:0]      csr_rdata;
  logic             csr_illegal;
  logic             excp_valid;
  logic [3:0]       excp_cause;
  logic [31:0]      excp_pc;
  logic [31:0]      excp_tval;
  logic             mret_valid;
  logic             irq_window;
  logic [31:0]      irq_pc;
  logic             irq_msi;
  logic             irq_mti;
  logic             irq_mei;
  logic [PlatW-1:0] irq_plat;
  logic             retire;
  logic             trap_req;
  logic [31:0]      trap_target;
  logic             trap_ack;

  modport master (
    output csr_valid, csr_op, csr_addr, csr_wdata, csr_uimm, csr_src_zero,
    output excp_valid, excp_cause, excp_pc, excp_tval, mret_valid,
    output irq_window, irq_pc, irq_msi, irq_mti, irq_mei, irq_plat, retire, trap_ack,
    input  csr_rdata, csr_illegal, trap_req, trap_target
  );

  modport slave (
    input  csr_valid, csr_op, csr_addr, csr_wdata, csr_uimm, csr_src_zero,
    input  excp_valid, excp_cause, excp_pc, excp_tval, mret_valid,
    input  irq_window, irq_pc, irq_msi, irq_mti, irq_mei, irq_plat, retire, trap_ack,
    output csr_rdata, csr_illegal, trap_req, trap_target
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode CSR file and trap controller (RV32 Zicsr).
// Ports:
//   clk  - core clock
//   nrst - asynchronous active-low reset
//   bus  - csr_trap_ctrl_if.slave: CSR access (0-latency read), exception/mret/interrupt
//          events, retire strobe, and the registered trap_req/trap_target/trap_ack handshake.
// Optional feature: define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters;
// otherwise their indices stay legal, read 0 and ignore writes.
module csr_trap_ctrl #(
  parameter int unsigned NUM_PLAT_IRQ = 4,
  parameter logic [31:0] HART_ID      = 32'd0
) (
  input logic            clk,
  input logic            nrst,
  csr_trap_ctrl_if.slave bus
);
  // Implemented interrupt bits: MSI(3), MTI(7), MEI(11), platform 16+i.
  localparam logic [31:0] IrqMask =
      32'h0000_0888 | (((32'd1 << NUM_PLAT_IRQ) - 32'd1) << 16);

  typedef enum logic {StRun, StHold} state_e;

  state_e      state_q, state_d;
  logic        trap_req_q, trap_req_d;
  logic [31:0] trap_target_q, trap_target_d;
  logic        mie_bit_q, mie_bit_d, mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mip_q, mip_d;
  logic [63:0] cnt_cycle, cnt_instret;

  logic        run, legal_addr, legal_op, wr_intent, csr_ill, csr_we, irq_take;
  logic [31:0] rd_val, src, wr_val, pend, mstatus_val, base;
  logic [4:0]  irq_code;

  assign run         = (state_q == StRun);
  assign mstatus_val = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_bit_q, 3'd0};
  assign pend        = mip_q & mie_q;
  assign base        = {mtvec_q[31:2], 2'b00};

  // Read mux and operation decode
  always_comb begin
    legal_addr = 1'b1;
    rd_val     = 32'd0;
    case (bus.csr_addr)
      12'hF11, 12'hF12, 12'hF13: rd_val = 32'd0;
      12'hF14: rd_val = HART_ID;
      12'h300: rd_val = mstatus_val;
      12'h301: rd_val = 32'h4000_1101;
      12'h304: rd_val = mie_q;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h343: rd_val = mtval_q;
      12'h344: rd_val = mip_q;
      12'hB00: rd_val = cnt_cycle[31:0];
      12'hB80: rd_val = cnt_cycle[63:32];
      12'hB02: rd_val = cnt_instret[31:0];
      12'hB82: rd_val = cnt_instret[63:32];
      default: legal_addr = 1'b0;
    endcase

    src       = bus.csr_op[2] ? {27'd0, bus.csr_uimm} : bus.csr_wdata;
    legal_op  = 1'b1;
    wr_intent = 1'b1;
    wr_val    = src;
    case (bus.csr_op[1:0])
      2'd1: wr_val = src;
      2'd2: begin
        wr_val    = rd_val | src;
        wr_intent = ~bus.csr_src_zero;
      end
      2'd3: begin
        wr_val    = rd_val & ~src;
        wr_intent = ~bus.csr_src_zero;
      end
      default: legal_op = 1'b0;
    endcase
  end

  assign csr_ill = run & bus.csr_valid &
                   (~legal_addr | ~legal_op | (wr_intent & (bus.csr_addr[11:10] == 2'b11)));
  assign irq_take = run & bus.irq_window & mie_bit_q & (|pend) &
                    ~bus.excp_valid & ~bus.mret_valid;
  // Any redirect in the same cycle suppresses the CSR write.
  assign csr_we = run & bus.csr_valid & ~csr_ill & wr_intent &
                  ~bus.excp_valid & ~bus.mret_valid & ~irq_take;

  assign bus.csr_rdata   = run ? rd_val : 32'd0;
  assign bus.csr_illegal = csr_ill;
  assign bus.trap_req    = trap_req_q;
  assign bus.trap_target = trap_target_q;

  // Highest-priority pending interrupt: MEI > MSI > MTI > lowest platform line.
  always_comb begin
    irq_code = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend[16+i]) irq_code = 5'(16 + i);
    end
    if (pend[7])  irq_code = 5'd7;
    if (pend[3])  irq_code = 5'd3;
    if (pend[11]) irq_code = 5'd11;
  end

  // FSM, trap side effects and CSR writes
  always_comb begin
    state_d       = state_q;
    trap_req_d    = trap_req_q;
    trap_target_d = trap_target_q;
    mie_bit_d     = mie_bit_q;
    mpie_d        = mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;

    mip_d        = 32'd0;
    mip_d[3]     = bus.irq_msi;
    mip_d[7]     = bus.irq_mti;
    mip_d[11]    = bus.irq_mei;
    for (int i = 0; i < int'(NUM_PLAT_IRQ); i++) mip_d[16+i] = bus.irq_plat[i];

    if (run) begin
      if (bus.excp_valid) begin
        state_d       = StHold;
        trap_req_d    = 1'b1;
        trap_target_d = base;
        mepc_d        = {bus.excp_pc[31:2], 2'b00};
        mcause_d      = {28'd0, bus.excp_cause};
        mtval_d       = bus.excp_tval;
        mpie_d        = mie_bit_q;
        mie_bit_d     = 1'b0;
      end else if (bus.mret_valid) begin
        state_d       = StHold;
        trap_req_d    = 1'b1;
        trap_target_d = mepc_q;
        mie_bit_d     = mpie_q;
        mpie_d        = 1'b1;
      end else if (irq_take) begin
        state_d       = StHold;
        trap_req_d    = 1'b1;
        trap_target_d = mtvec_q[0] ? base + {25'd0, irq_code, 2'b00} : base;
        mepc_d        = {bus.irq_pc[31:2], 2'b00};
        mcause_d      = {1'b1, 26'd0, irq_code};
        mtval_d       = 32'd0;
        mpie_d        = mie_bit_q;
        mie_bit_d     = 1'b0;
      end else if (csr_we) begin
        case (bus.csr_addr)
          12'h300: begin
            mie_bit_d = wr_val[3];
            mpie_d    = wr_val[7];
          end
          12'h304: mie_d      = wr_val & IrqMask;
          // Reserved modes 2/3 keep the current mode.
          12'h305: mtvec_d    = {wr_val[31:2], wr_val[1] ? mtvec_q[1:0] : wr_val[1:0]};
          12'h340: mscratch_d = wr_val;
          12'h341: mepc_d     = {wr_val[31:2], 2'b00};
          12'h342: mcause_d   = wr_val;
          12'h343: mtval_d    = wr_val;
          default: ;
        endcase
      end
    end else if (bus.trap_ack) begin
      state_d    = StRun;
      trap_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= StRun;
      trap_req_q    <= 1'b0;
      trap_target_q <= 32'd0;
      mie_bit_q     <= 1'b0;
      mpie_q        <= 1'b0;
      mie_q         <= 32'd0;
      mtvec_q       <= 32'd0;
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
      mip_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      trap_req_q    <= trap_req_d;
      trap_target_q <= trap_target_d;
      mie_bit_q     <= mie_bit_d;
      mpie_q        <= mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mip_q         <= mip_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  // A write to one half replaces that half's increment; a low-half carry still
  // reaches the high half unless the high half is the one written.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, bus.retire};
    if (csr_we) begin
      case (bus.csr_addr)
        12'hB00: mcycle_d[31:0]    = wr_val;
        12'hB80: mcycle_d[63:32]   = wr_val;
        12'hB02: minstret_d[31:0]  = wr_val;
        12'hB82: minstret_d[63:32] = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign cnt_cycle   = mcycle_q;
  assign cnt_instret = minstret_q;
`else
  logic unused_retire;
  assign unused_retire = bus.retire;
  assign cnt_cycle     = 64'd0;
  assign cnt_instret   = 64'd0;
`endif

endmodule
